// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode definitions: instruction class codes,
// opcode constants and the decoded-record layout.
package decode_queue_pkg;

   localparam logic [5:0] T_LUI     = 6'd0;
   localparam logic [5:0] T_AUIPC   = 6'd1;
   localparam logic [5:0] T_JAL     = 6'd2;
   localparam logic [5:0] T_JALR    = 6'd3;
   localparam logic [5:0] T_BEQ     = 6'd4;
   localparam logic [5:0] T_BNE     = 6'd5;
   localparam logic [5:0] T_BLT     = 6'd6;
   localparam logic [5:0] T_BGE     = 6'd7;
   localparam logic [5:0] T_BLTU    = 6'd8;
   localparam logic [5:0] T_BGEU    = 6'd9;
   localparam logic [5:0] T_LB      = 6'd10;
   localparam logic [5:0] T_LH      = 6'd11;
   localparam logic [5:0] T_LW      = 6'd12;
   localparam logic [5:0] T_LBU     = 6'd13;
   localparam logic [5:0] T_LHU     = 6'd14;
   localparam logic [5:0] T_SB      = 6'd15;
   localparam logic [5:0] T_SH      = 6'd16;
   localparam logic [5:0] T_SW      = 6'd17;
   localparam logic [5:0] T_ADDI    = 6'd18;
   localparam logic [5:0] T_SLTI    = 6'd19;
   localparam logic [5:0] T_SLTIU   = 6'd20;
   localparam logic [5:0] T_XORI    = 6'd21;
   localparam logic [5:0] T_ORI     = 6'd22;
   localparam logic [5:0] T_ANDI    = 6'd23;
   localparam logic [5:0] T_SLLI    = 6'd24;
   localparam logic [5:0] T_SRLI    = 6'd25;
   localparam logic [5:0] T_SRAI    = 6'd26;
   localparam logic [5:0] T_ADD     = 6'd27;
   localparam logic [5:0] T_SUB     = 6'd28;
   localparam logic [5:0] T_SLL     = 6'd29;
   localparam logic [5:0] T_SLT     = 6'd30;
   localparam logic [5:0] T_SLTU    = 6'd31;
   localparam logic [5:0] T_XOR     = 6'd32;
   localparam logic [5:0] T_SRL     = 6'd33;
   localparam logic [5:0] T_SRA     = 6'd34;
   localparam logic [5:0] T_OR      = 6'd35;
   localparam logic [5:0] T_AND     = 6'd36;
   localparam logic [5:0] T_ILLEGAL = 6'd37;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [5:0]  itype;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_rs1;
      logic        use_rs2;
      logic        write_rd;
   } dec_rec_t;

endpackage

// File: rtl/decode_queue_inst_decode.sv
// Combinational RV32I decoder: raw instruction word to decoded record.
// Illegal encodings collapse to T_ILLEGAL with zero imm and flags.
module inst_decode
   import decode_queue_pkg::*;
(
   input  logic [31:0] i_inst,
   output dec_rec_t    o_rec
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm_sh;
   logic [5:0]  w_type;
   logic [31:0] w_imm;
   logic        w_u1;
   logic        w_u2;
   logic        w_wr;

   assign w_opc = i_inst[6:0];
   assign w_f3  = i_inst[14:12];
   assign w_f7  = i_inst[31:25];

   assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
   assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
   assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                      i_inst[30:25], i_inst[11:8], 1'b0};
   assign w_imm_u  = {i_inst[31:12], 12'b0};
   assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                      i_inst[20], i_inst[30:21], 1'b0};
   assign w_imm_sh = {27'b0, i_inst[24:20]};

   always_comb begin
      w_type = T_ILLEGAL;
      w_imm  = '0;
      w_u1   = 1'b0;
      w_u2   = 1'b0;
      w_wr   = 1'b0;
      case (w_opc)
         OPC_LUI: begin
            w_type = T_LUI;
            w_imm  = w_imm_u;
            w_wr   = 1'b1;
         end
         OPC_AUIPC: begin
            w_type = T_AUIPC;
            w_imm  = w_imm_u;
            w_wr   = 1'b1;
         end
         OPC_JAL: begin
            w_type = T_JAL;
            w_imm  = w_imm_j;
            w_wr   = 1'b1;
         end
         OPC_JALR: begin
            if (w_f3 == 3'b000) w_type = T_JALR;
            w_imm = w_imm_i;
            w_u1  = 1'b1;
            w_wr  = 1'b1;
         end
         OPC_BRANCH: begin
            case (w_f3)
               3'b000:  w_type = T_BEQ;
               3'b001:  w_type = T_BNE;
               3'b100:  w_type = T_BLT;
               3'b101:  w_type = T_BGE;
               3'b110:  w_type = T_BLTU;
               3'b111:  w_type = T_BGEU;
               default: w_type = T_ILLEGAL;
            endcase
            w_imm = w_imm_b;
            w_u1  = 1'b1;
            w_u2  = 1'b1;
         end
         OPC_LOAD: begin
            case (w_f3)
               3'b000:  w_type = T_LB;
               3'b001:  w_type = T_LH;
               3'b010:  w_type = T_LW;
               3'b100:  w_type = T_LBU;
               3'b101:  w_type = T_LHU;
               default: w_type = T_ILLEGAL;
            endcase
            w_imm = w_imm_i;
            w_u1  = 1'b1;
            w_wr  = 1'b1;
         end
         OPC_STORE: begin
            case (w_f3)
               3'b000:  w_type = T_SB;
               3'b001:  w_type = T_SH;
               3'b010:  w_type = T_SW;
               default: w_type = T_ILLEGAL;
            endcase
            w_imm = w_imm_s;
            w_u1  = 1'b1;
            w_u2  = 1'b1;
         end
         OPC_OPIMM: begin
            w_imm = w_imm_i;
            w_u1  = 1'b1;
            w_wr  = 1'b1;
            case (w_f3)
               3'b000: w_type = T_ADDI;
               3'b010: w_type = T_SLTI;
               3'b011: w_type = T_SLTIU;
               3'b100: w_type = T_XORI;
               3'b110: w_type = T_ORI;
               3'b111: w_type = T_ANDI;
               3'b001: begin
                  w_imm = w_imm_sh;
                  if (w_f7 == F7_BASE) w_type = T_SLLI;
               end
               default: begin
                  w_imm = w_imm_sh;
                  if (w_f7 == F7_BASE) w_type = T_SRLI;
                  else if (w_f7 == F7_ALT) w_type = T_SRAI;
               end
            endcase
         end
         OPC_OP: begin
            w_u1 = 1'b1;
            w_u2 = 1'b1;
            w_wr = 1'b1;
            if (w_f7 == F7_BASE) begin
               case (w_f3)
                  3'b000:  w_type = T_ADD;
                  3'b001:  w_type = T_SLL;
                  3'b010:  w_type = T_SLT;
                  3'b011:  w_type = T_SLTU;
                  3'b100:  w_type = T_XOR;
                  3'b101:  w_type = T_SRL;
                  3'b110:  w_type = T_OR;
                  default: w_type = T_AND;
               endcase
            end else if (w_f7 == F7_ALT) begin
               if (w_f3 == 3'b000) w_type = T_SUB;
               else if (w_f3 == 3'b101) w_type = T_SRA;
            end
         end
         default: w_type = T_ILLEGAL;
      endcase
      // any rejected encoding drops everything the branch above set up
      if (w_type == T_ILLEGAL) begin
         w_imm = '0;
         w_u1  = 1'b0;
         w_u2  = 1'b0;
         w_wr  = 1'b0;
      end
   end

   assign o_rec.itype    = w_type;
   assign o_rec.rs1      = i_inst[19:15];
   assign o_rec.rs2      = i_inst[24:20];
   assign o_rec.rd       = i_inst[11:7];
   assign o_rec.imm      = w_imm;
   assign o_rec.use_rs1  = w_u1;
   assign o_rec.use_rs2  = w_u2;
   assign o_rec.write_rd = w_wr & (i_inst[11:7] != 5'd0);

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: decodes on entry, queues DEPTH decoded
// records and presents the head to dispatch.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PC_WIDTH = 32
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       rdy_in,
   input  logic                       flush_in,
   input  logic                       in_valid,
   input  logic [31:0]                in_inst,
   input  logic [PC_WIDTH-1:0]        in_pc,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [5:0]                 out_type,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [4:0]                 out_rd,
   output logic [31:0]                out_imm,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic                       out_use_rs1,
   output logic                       out_use_rs2,
   output logic                       out_write_rd,
   output logic [$clog2(DEPTH):0]     out_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   dec_rec_t            r_rec [DEPTH];
   logic [PC_WIDTH-1:0] r_pc  [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;

   dec_rec_t w_dec;
   dec_rec_t w_head;
   logic     w_full;
   logic     w_empty;
   logic     w_push;
   logic     w_pop;

   inst_decode u_dec (
      .i_inst (in_inst),
      .o_rec  (w_dec)
   );

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign in_ready  = rdy_in & ~flush_in & ~w_full;
   assign out_valid = rdy_in & ~flush_in & ~w_empty;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (rdy_in) begin
         if (flush_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // storage is not reset; validity is tracked by r_count alone
   always_ff @(posedge clk_in) begin
      if (w_push & ~rst_in) begin
         r_rec[r_wr_ptr] <= w_dec;
         r_pc[r_wr_ptr]  <= in_pc;
      end
   end

   assign w_head       = r_rec[r_rd_ptr];
   assign out_type     = w_head.itype;
   assign out_rs1      = w_head.rs1;
   assign out_rs2      = w_head.rs2;
   assign out_rd       = w_head.rd;
   assign out_imm      = w_head.imm;
   assign out_pc       = r_pc[r_rd_ptr];
   assign out_use_rs1  = w_head.use_rs1;
   assign out_use_rs2  = w_head.use_rs2;
   assign out_write_rd = w_head.write_rd;
   assign out_count    = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode values, full/flush/stall
// behaviour, all against hand-computed expectations.
module tb_decode_queue;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush_in;
   logic        in_valid;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_type;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic [31:0] out_pc;
   logic        out_use_rs1;
   logic        out_use_rs2;
   logic        out_write_rd;
   logic [2:0]  out_count;

   int checks = 0;
   int errors = 0;

   decode_queue #(.DEPTH(4), .PC_WIDTH(32)) dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .rdy_in       (rdy_in),
      .flush_in     (flush_in),
      .in_valid     (in_valid),
      .in_inst      (in_inst),
      .in_pc        (in_pc),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_type     (out_type),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_rd       (out_rd),
      .out_imm      (out_imm),
      .out_pc       (out_pc),
      .out_use_rs1  (out_use_rs1),
      .out_use_rs2  (out_use_rs2),
      .out_write_rd (out_write_rd),
      .out_count    (out_count)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic push_one(input logic [31:0] inst,
                           input logic [31:0] pc);
      in_inst  = inst;
      in_pc    = pc;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [5:0] ty,
                           input logic [31:0] imm, input logic u1,
                           input logic u2, input logic wr,
                           input logic [31:0] pc);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_type"}, 32'(out_type), 32'(ty));
      chk({tag, "_imm"}, out_imm, imm);
      chk({tag, "_flags"}, {29'd0, out_use_rs1, out_use_rs2,
                            out_write_rd}, {29'd0, u1, u2, wr});
      chk({tag, "_pc"}, out_pc, pc);
   endtask

   initial begin
      rst_in    = 1'b1;
      rdy_in    = 1'b1;
      flush_in  = 1'b0;
      in_valid  = 1'b0;
      in_inst   = 32'h0;
      in_pc     = 32'h0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_in = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // ADDI x1,x0,-1
      push_one(32'hFFF00093, 32'h100);
      chk_head("addi", 6'd18, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h100);
      chk("addi_rd", 32'(out_rd), 32'd1);
      chk("addi_count", 32'(out_count), 32'd1);
      pop_one();
      chk("addi_drained", 32'(out_count), 32'd0);

      // fill: BEQ -4, SRAI, bad SLLI, LUI
      push_one(32'hFE000EE3, 32'h200);
      push_one(32'h40105093, 32'h204);
      push_one(32'h40101093, 32'h208);
      chk("fill_in_ready_3", 32'(in_ready), 32'd1);
      push_one(32'h12345237, 32'h20C);
      chk("full_count", 32'(out_count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk_head("beq", 6'd4, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 32'h200);
      chk("beq_rd_raw", 32'(out_rd), 32'd29);

      // offer a push while full and popping: push must be refused
      in_inst   = 32'h00000013;
      in_pc     = 32'h300;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("full_pop_in_ready", 32'(in_ready), 32'd0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("full_pop_count", 32'(out_count), 32'd3);
      chk_head("srai", 6'd26, 32'h1, 1'b1, 1'b0, 1'b1, 32'h204);
      pop_one();
      chk_head("slli_bad", 6'd37, 32'h0, 1'b0, 1'b0, 1'b0, 32'h208);
      pop_one();
      chk_head("lui", 6'd0, 32'h12345000, 1'b0, 1'b0, 1'b1, 32'h20C);
      chk("lui_rd", 32'(out_rd), 32'd4);
      pop_one();
      chk("drain_count", 32'(out_count), 32'd0);
      chk("drain_valid", 32'(out_valid), 32'd0);

      // SW x2,8(x1), then push ADD while popping
      push_one(32'h0020A423, 32'h400);
      chk_head("sw", 6'd17, 32'h8, 1'b1, 1'b1, 1'b0, 32'h400);
      in_inst   = 32'h002081B3;
      in_pc     = 32'h404;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("pushpop_count", 32'(out_count), 32'd1);
      chk_head("add", 6'd27, 32'h0, 1'b1, 1'b1, 1'b1, 32'h404);
      chk("add_rd", 32'(out_rd), 32'd3);
      pop_one();

      // flush at count=3 with push and pop offered
      push_one(32'hFFF00093, 32'h500);
      push_one(32'hFFF00093, 32'h504);
      push_one(32'hFFF00093, 32'h508);
      chk("preflush_count", 32'(out_count), 32'd3);
      flush_in  = 1'b1;
      in_inst   = 32'h00000013;
      in_pc     = 32'h50C;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      tick();
      flush_in  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("postflush_count", 32'(out_count), 32'd0);
      chk("postflush_valid", 32'(out_valid), 32'd0);

      // SUB x2,x1,x2 then LW x5,-8(x2)
      push_one(32'h40208133, 32'h600);
      chk_head("sub", 6'd28, 32'h0, 1'b1, 1'b1, 1'b1, 32'h600);
      push_one(32'hFF812283, 32'h604);
      chk("prestall_count", 32'(out_count), 32'd2);

      // freeze for three cycles with both sides offering
      rdy_in    = 1'b0;
      in_inst   = 32'h00000013;
      in_pc     = 32'h608;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd0);
         tick();
         chk("stall_count", 32'(out_count), 32'd2);
         chk("stall_head_type", 32'(out_type), 32'd28);
      end
      rdy_in = 1'b1;
      #1;
      chk("resume_out_valid", 32'(out_valid), 32'd1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("resume_count", 32'(out_count), 32'd2);
      chk_head("lw", 6'd12, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b1, 32'h604);
      chk("lw_rd", 32'(out_rd), 32'd5);
      pop_one();
      chk_head("nop", 6'd18, 32'h0, 1'b1, 1'b0, 1'b0, 32'h608);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
